// File: rtl/sltu.sv
// Unsigned set-less-than for the execute stage: combinational A<B via a borrow
// chain, plus a registered zero-extended result with a one-cycle valid strobe.
module sltu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  output logic             lt_comb
);

  logic [WIDTH:0] w_borrow;
  logic           r_lt;
  logic           r_out_valid;

  // Ripple borrow of A - B; the borrow out of the MSB is set exactly when A < B.
  assign w_borrow[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_borrow
    assign w_borrow[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_borrow[i]);
  end

  assign lt_comb = w_borrow[WIDTH];

  // Result bit only loads on in_valid, so undriven operands while idle never reach Y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lt        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_lt <= w_borrow[WIDTH];
      end
    end
  end

  assign Y         = {{(WIDTH-1){1'b0}}, r_lt};
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sltu.sv
// Scoreboard bench for sltu: the driver queues expected results, a negedge
// monitor pops one per out_valid and compares Y.
module tb_sltu;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Y;
  logic         out_valid;
  logic         lt_comb;

  typedef struct {
    logic  exp;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  sltu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Y         (Y),
    .out_valid (out_valid),
    .lt_comb   (lt_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one operand pair just after a rising edge; lt_comb is checked in the same cycle.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic exp,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    e.exp    = exp;
    e.name   = name;
    exp_q.push_back(e);
    #1;
    chk({name, "_lt_comb"}, {{(W-1){1'b0}}, lt_comb}, {{(W-1){1'b0}}, exp});
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = 'x;
    B        = 'x;
  endtask

  // Idle one more edge, then confirm out_valid dropped and Y held.
  task automatic idle_check(input logic exp_y, input string name);
    idle();
    @(posedge clk);
    #2;
    chk({name, "_out_valid"}, {{(W-1){1'b0}}, out_valid}, '0);
    chk({name, "_Y_hold"}, Y, {{(W-1){1'b0}}, exp_y});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got Y=%h with no result pending", Y);
        end else begin
          e = exp_q.pop_front();
          chk(e.name, Y, {{(W-1){1'b0}}, e.exp});
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    #2;
    chk("reset_Y", Y, '0);
    chk("reset_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    #10;
    rst_n = 1'b1;

    send(64'd23, 64'd23, 1'b0, "equal_23");
    send(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "zero_lt_ones");
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, "ones_vs_zero");
    send(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, "sign_bit_large");
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, "sign_bit_small");
    send(64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b1, "word_boundary");
    send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, "equal_pattern");
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "equal_ones");
    send(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "ones_minus_one");
    send(64'd1, 64'd2, 1'b1, "stream_1_2");
    send(64'd2, 64'd1, 1'b0, "stream_2_1");
    send(64'd5, 64'd5, 1'b0, "stream_5_5");
    idle_check(1'b0, "after_stream");

    send(64'd0, 64'd1, 1'b1, "pre_reset");
    idle();
    #6;
    rst_n = 1'b0;
    #1;
    chk("async_reset_Y", Y, '0);
    chk("async_reset_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    A        = 64'd1;
    B        = 64'd2;
    in_valid = 1'b1;
    #1;
    chk("lt_comb_in_reset", {{(W-1){1'b0}}, lt_comb}, 64'd1);
    @(posedge clk);
    #2;
    chk("reset_wins_Y", Y, '0);
    chk("reset_wins_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;

    send(64'd3, 64'd4, 1'b1, "post_reset_3_4");
    idle_check(1'b1, "hold_with_x_operands");

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
